// File: rtl/ahb3lite_host_initiator.sv
// Host-side initiator for the AHB3-lite bridge byte protocol: serializes one bus
// request into command bytes and parses the bridge's status/data response bytes.
module ahb3lite_host_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] rsp_rdata,
  output logic        fifo_wren,
  input  logic        fifo_wrfull,
  output logic [7:0]  fifo_wrdata,
  output logic        fifo_rden,
  input  logic        fifo_rdempty,
  input  logic [7:0]  fifo_rddata
);

  typedef enum logic [2:0] {
    IDLE, TX_CMD, TX_ADDR, TX_DATA, RX_STAT, RX_DATA, DONE
  } state_t;

  state_t      state_reg;
  logic        write_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] shift_reg;
  logic [31:0] tcnt_reg;
  logic [1:0]  idx_reg;
  logic        pend_reg;

  logic        tx_active;
  logic        rx_active;
  logic        timeout_hit;
  logic [31:0] tcnt_inc;

  always_comb begin
    tx_active   = (state_reg == TX_CMD) || (state_reg == TX_ADDR) || (state_reg == TX_DATA);
    rx_active   = (state_reg == RX_STAT) || (state_reg == RX_DATA);
    tcnt_inc    = (tcnt_reg == 32'hFFFF_FFFF) ? tcnt_reg : tcnt_reg + 32'd1;
    timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (tcnt_inc >= TIMEOUT_CYCLES);
    fifo_wren   = tx_active && !fifo_wrfull;
    // No new pop once the abort is decided, so remaining bytes stay in the FIFO.
    fifo_rden   = rx_active && !pend_reg && !fifo_rdempty && !timeout_hit;
    case (state_reg)
      TX_CMD:  fifo_wrdata = {write_reg, 5'b00000, size_reg};
      TX_ADDR: fifo_wrdata = addr_reg[{idx_reg, 3'b000} +: 8];
      TX_DATA: fifo_wrdata = wdata_reg[{idx_reg, 3'b000} +: 8];
      default: fifo_wrdata = 8'h00;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_reg   <= IDLE;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= 32'd0;
      write_reg   <= 1'b0;
      size_reg    <= 2'd0;
      addr_reg    <= 32'd0;
      wdata_reg   <= 32'd0;
      shift_reg   <= 32'd0;
      tcnt_reg    <= 32'd0;
      idx_reg     <= 2'd0;
      pend_reg    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid && req_ready) begin
            write_reg   <= req_write;
            size_reg    <= req_size;
            addr_reg    <= req_addr;
            wdata_reg   <= req_wdata;
            shift_reg   <= 32'd0;
            idx_reg     <= 2'd0;
            pend_reg    <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= 32'd0;
            req_ready   <= 1'b0;
            state_reg   <= TX_CMD;
          end else begin
            req_ready <= 1'b1;
          end
        end
        TX_CMD: begin
          if (fifo_wren) state_reg <= TX_ADDR;
        end
        TX_ADDR: begin
          if (fifo_wren) begin
            idx_reg <= idx_reg + 2'd1;
            if (idx_reg == 2'd3) begin
              state_reg <= write_reg ? TX_DATA : RX_STAT;
              tcnt_reg  <= 32'd0;
              pend_reg  <= 1'b0;
            end
          end
        end
        TX_DATA: begin
          if (fifo_wren) begin
            idx_reg <= idx_reg + 2'd1;
            if (idx_reg == 2'd3) begin
              state_reg <= RX_STAT;
              tcnt_reg  <= 32'd0;
              pend_reg  <= 1'b0;
            end
          end
        end
        RX_STAT: begin
          tcnt_reg <= tcnt_inc;
          if (fifo_rden) pend_reg <= 1'b1;
          if (pend_reg) begin
            pend_reg <= 1'b0;
            if (fifo_rddata != 8'h00) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state_reg <= DONE;
            end else if (write_reg) begin
              rsp_valid <= 1'b1;
              state_reg <= DONE;
            end else begin
              idx_reg   <= 2'd0;
              state_reg <= RX_DATA;
            end
          end else if (timeout_hit) begin
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state_reg   <= DONE;
          end
        end
        RX_DATA: begin
          tcnt_reg <= tcnt_inc;
          if (fifo_rden) pend_reg <= 1'b1;
          if (pend_reg) begin
            pend_reg  <= 1'b0;
            shift_reg <= {fifo_rddata, shift_reg[31:8]};
            idx_reg   <= idx_reg + 2'd1;
            if (idx_reg == 2'd3) begin
              rsp_rdata <= {fifo_rddata, shift_reg[31:8]};
              rsp_valid <= 1'b1;
              state_reg <= DONE;
            end
          end else if (timeout_hit) begin
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          req_ready <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb3lite_host_initiator.sv
// Bench for ahb3lite_host_initiator: queue-based byte FIFO models on both sides
// and a frame/response reference model derived from the protocol rules.
module tb_ahb3lite_host_initiator;
  localparam int unsigned TMO = 16;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        fifo_wren;
  logic        fifo_wrfull = 1'b0;
  logic [7:0]  fifo_wrdata;
  logic        fifo_rden;
  logic        fifo_rdempty = 1'b1;
  logic [7:0]  fifo_rddata = 8'h00;

  ahb3lite_host_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .rsp_rdata(rsp_rdata),
    .fifo_wren(fifo_wren), .fifo_wrfull(fifo_wrfull), .fifo_wrdata(fifo_wrdata),
    .fifo_rden(fifo_rden), .fifo_rdempty(fifo_rdempty), .fifo_rddata(fifo_rddata)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int pops = 0;
  int full_at = 0;
  int full_left = 0;
  bit full_rand = 1'b0;
  bit full_seen = 1'b0;
  byte unsigned wq[$];
  byte unsigned rxq[$];
  int push_cyc[$];

  logic        s_wren, s_rden, s_rv, s_err, s_tmo, s_ready;
  logic [7:0]  s_wdata;
  logic [31:0] s_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sample outputs on the falling edge, then update the FIFO models after the rising edge.
  task automatic tick();
    @(negedge CLK);
    cyc++;
    s_wren = fifo_wren; s_wdata = fifo_wrdata; s_rden = fifo_rden;
    s_rv = rsp_valid; s_err = rsp_err; s_tmo = rsp_timeout;
    s_rdata = rsp_rdata; s_ready = req_ready;
    @(posedge CLK);
    #1;
    if (s_wren) begin
      wq.push_back(s_wdata);
      push_cyc.push_back(cyc);
    end
    if (s_rden) begin
      fifo_rddata = rxq.pop_front();
      pops++;
    end
    fifo_rdempty = (rxq.size() == 0);
    if (full_left > 0 && wq.size() >= full_at) begin
      fifo_wrfull = 1'b1; full_left--; full_seen = 1'b1;
    end else if (full_rand && $urandom_range(0, 3) == 0) begin
      fifo_wrfull = 1'b1; full_seen = 1'b1;
    end else begin
      fifo_wrfull = 1'b0;
    end
  endtask

  task automatic load_rx(input byte unsigned b);
    rxq.push_back(b);
    fifo_rdempty = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "/req_ready"}, req_ready, 0);
    chk({tag, "/rsp_valid"}, rsp_valid, 0);
    chk({tag, "/rsp_err"}, rsp_err, 0);
    chk({tag, "/rsp_timeout"}, rsp_timeout, 0);
    chk({tag, "/rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "/fifo_wren"}, fifo_wren, 0);
    chk({tag, "/fifo_wrdata"}, fifo_wrdata, 0);
    chk({tag, "/fifo_rden"}, fifo_rden, 0);
  endtask

  task automatic accept(input bit wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                        input string name);
    bit got;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_addr = a; req_wdata = d;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      got = s_ready;
    end
    chk({name, "/accept"}, got, 1);
    req_valid = 1'b0;
    req_write = 1'($urandom); req_size = 2'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
  endtask

  // The response bytes the bridge will return must already be queued in rxq.
  task automatic run_txn(input string name, input bit wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
    byte unsigned exp_frame[$];
    byte unsigned rs[$];
    bit e_tmo, e_err, got;
    logic [31:0] e_rdata;
    int consumed, e_lat, rv_cyc, nchk;
    rs = rxq;
    exp_frame.push_back({wr, 5'b00000, sz});
    for (int i = 0; i < 4; i++) exp_frame.push_back(a[8*i +: 8]);
    if (wr) for (int i = 0; i < 4; i++) exp_frame.push_back(d[8*i +: 8]);
    e_tmo = (rs.size() == 0) || (!wr && rs[0] == 0 && rs.size() < 5);
    e_err = !e_tmo && (rs[0] != 0);
    e_rdata = 32'd0;
    if (!e_tmo && !e_err && !wr) e_rdata = {rs[4], rs[3], rs[2], rs[1]};
    consumed = e_tmo ? 0 : ((e_err || wr) ? 1 : 5);
    // Each response byte costs two cycles: pop, then capture.
    e_lat = e_tmo ? int'(TMO) + 1 : ((e_err || wr) ? 3 : 11);

    wq.delete(); push_cyc.delete(); full_seen = 1'b0; pops = 0;
    accept(wr, sz, a, d, name);
    got = 1'b0;
    for (int n = 0; n < 400 && !got; n++) begin
      tick();
      got = s_rv;
    end
    chk({name, "/rsp_valid"}, got, 1);
    rv_cyc = cyc;
    chk({name, "/rsp_err"}, s_err, e_err);
    chk({name, "/rsp_timeout"}, s_tmo, e_tmo);
    chk({name, "/rsp_rdata"}, s_rdata, e_rdata);
    chk({name, "/frame_len"}, wq.size(), exp_frame.size());
    nchk = (wq.size() < exp_frame.size()) ? wq.size() : exp_frame.size();
    for (int i = 0; i < nchk; i++) chk($sformatf("%s/byte%0d", name, i), wq[i], exp_frame[i]);
    if (push_cyc.size() > 0) chk({name, "/latency"}, rv_cyc - push_cyc[$], e_lat);
    if (!full_seen && push_cyc.size() > 0)
      chk({name, "/tx_span"}, push_cyc[$] - push_cyc[0], exp_frame.size() - 1);
    tick();
    chk({name, "/pulse"}, s_rv, 0);
    chk({name, "/ready_back"}, s_ready, 1);
    chk({name, "/err_held"}, s_err, e_err);
    chk({name, "/rdata_held"}, s_rdata, e_rdata);
    chk({name, "/rx_left"}, rxq.size(), rs.size() - consumed);
    $display("txn %s: %s size=%0d addr=%08h wdata=%08h -> err=%0b timeout=%0b rdata=%08h",
             name, wr ? "WR" : "RD", sz, a, d, s_err, s_tmo, s_rdata);
    rxq.delete();
    fifo_rdempty = 1'b1;
  endtask

  initial begin
    bit wr, got;
    byte unsigned st;

    // Reset state, then ready one edge after release
    #12;
    chk_outputs_zero("reset");
    @(posedge CLK); #1;
    RESETn = 1'b1;
    tick();
    tick();
    chk("reset/ready_after", s_ready, 1);

    // Stray bytes in IDLE are never popped
    load_rx(8'h5A); pops = 0;
    for (int n = 0; n < 6; n++) tick();
    chk("stray/pops", pops, 0);
    chk("stray/left", rxq.size(), 1);
    rxq.delete(); fifo_rdempty = 1'b1;

    load_rx(8'h00);
    run_txn("t1_write", 1'b1, 2'd2, 32'h2000_0010, 32'hDEAD_BEEF);

    load_rx(8'h00); load_rx(8'h78); load_rx(8'h56); load_rx(8'h34); load_rx(8'h12);
    run_txn("t2_read", 1'b0, 2'd2, 32'h0000_0004, 32'h0);

    load_rx(8'h01); load_rx(8'hAA); load_rx(8'hBB);
    run_txn("t3_rderr", 1'b0, 2'd2, 32'h0000_0008, 32'h0);

    full_at = 3; full_left = 20;
    load_rx(8'h00);
    run_txn("t4_stall", 1'b1, 2'd2, 32'h2000_0010, 32'hDEAD_BEEF);
    full_left = 0;

    run_txn("t5_timeout", 1'b0, 2'd2, 32'h1234_5678, 32'h0);

    load_rx(8'h00);
    run_txn("size3", 1'b1, 2'd3, 32'hCAFE_F00D, 32'h0102_0304);

    // Reset while waiting for data byte 2 of a read
    load_rx(8'h00); load_rx(8'h11);
    pops = 0;
    accept(1'b0, 2'd2, 32'h0000_0040, 32'h0, "t6");
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      tick();
      got = (pops == 2);
    end
    chk("t6/reached_rx_data", got, 1);
    tick();
    tick();
    RESETn = 1'b0;
    #1;
    chk_outputs_zero("t6_reset");
    for (int n = 0; n < 3; n++) tick();
    chk("t6/no_pops_in_reset", pops, 2);
    RESETn = 1'b1;
    rxq.delete(); fifo_rdempty = 1'b1;
    tick();
    tick();
    load_rx(8'h00); load_rx(8'hEF); load_rx(8'hCD); load_rx(8'hAB); load_rx(8'h89);
    run_txn("t6_after", 1'b0, 2'd2, 32'h0000_0044, 32'h0);

    // Randomized traffic with random write-FIFO backpressure
    full_rand = 1'b1;
    for (int k = 0; k < 30; k++) begin
      wr = 1'($urandom);
      st = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      load_rx(st);
      if (st != 8'h00) begin
        load_rx(8'($urandom)); load_rx(8'($urandom));
      end else if (!wr) begin
        for (int i = 0; i < 4; i++) load_rx(8'($urandom));
      end else if ($urandom_range(0, 1) == 1) begin
        load_rx(8'($urandom));
      end
      run_txn($sformatf("rnd%0d", k), wr, 2'($urandom), $urandom, $urandom);
    end
    full_rand = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
